// File: rtl/exposure_timer_pkg.sv
// timer_pkg: shared state encoding, width helper and parameter sanity check for the exposure timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Smallest bit count able to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // LIMIT_HI must saturate the counter before it could wrap.
    function automatic bit params_ok(input int cnt_w, input int presc, input int lo, input int hi);
        return presc >= 1 && lo >= 1 && lo < hi && hi <= (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/exposure_timer_if.sv
// exposure_timer_if: control/status bundle between camera FSM (master) and timer (slave); Hold only with TIMER_PAUSE_EN.
interface exposure_timer_if #(
    parameter int CNT_W = 5
);
    logic             Initial;
    logic             Start;
    logic [CNT_W-1:0] Count;
    logic             Busy;
    logic             Ovf_lo;
    logic             Ovf_hi;
    logic             Done;
`ifdef TIMER_PAUSE_EN
    logic             Hold;

    modport master (output Initial, Start, Hold, input Count, Busy, Ovf_lo, Ovf_hi, Done);
    modport slave  (input Initial, Start, Hold, output Count, Busy, Ovf_lo, Ovf_hi, Done);
`else
    modport master (output Initial, Start, input Count, Busy, Ovf_lo, Ovf_hi, Done);
    modport slave  (input Initial, Start, output Count, Busy, Ovf_lo, Ovf_hi, Done);
`endif
endinterface

// File: rtl/exposure_timer_prescaler.sv
// timer_prescaler: divides the clock into count ticks, one tick every PRESC enabled cycles.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESC = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    generate
        if (PRESC == 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{Clk, Reset, clear};
            assign tick = enable;
        end else begin : g_div
            localparam int PW = clog2(PRESC);
            localparam logic [PW-1:0] LAST = PW'(PRESC - 1);
            logic [PW-1:0] cnt;
            // Free-running 0..PRESC-1 phase counter, frozen when not enabled.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset)
                    cnt <= '0;
                else if (clear)
                    cnt <= '0;
                else if (enable)
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            assign tick = enable && cnt == LAST;
        end
    endgenerate

endmodule

// File: rtl/exposure_timer.sv
// exposure_timer: prescaled exposure counter with low/high thresholds; macro TIMER_PAUSE_EN adds the Hold pause input.
module exposure_timer
    import timer_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int PRESC    = 1,
    parameter int LIMIT_LO = 4,
    parameter int LIMIT_HI = 5
) (
    input logic              Clk,
    input logic              Reset,
    exposure_timer_if.slave  bus
);

    localparam bit PARAMS_OK = params_ok(CNT_W, PRESC, LIMIT_LO, LIMIT_HI);
    localparam logic [CNT_W-1:0] LO_V = LIMIT_LO[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HI_V = LIMIT_HI[CNT_W-1:0];

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("exposure_timer: need PRESC>=1, 1<=LIMIT_LO<LIMIT_HI<=2^CNT_W-1");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             busy;
    logic             ovf_lo;
    logic             ovf_hi;
    logic             done;
    logic             hold;
    logic             tick;

`ifdef TIMER_PAUSE_EN
    assign hold = bus.Hold;
`else
    assign hold = 1'b0;
`endif

    assign next_count = count + 1'b1;

    timer_prescaler #(.PRESC(PRESC)) u_prescaler (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (bus.Initial || state != RUN),
        .enable (state == RUN && !hold),
        .tick   (tick)
    );

    // Control FSM; every status output is a register so downstream sees glitch-free levels.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            count  <= '0;
            busy   <= 1'b0;
            ovf_lo <= 1'b0;
            ovf_hi <= 1'b0;
            done   <= 1'b0;
        end else if (bus.Initial) begin
            state  <= IDLE;
            count  <= '0;
            busy   <= 1'b0;
            ovf_lo <= 1'b0;
            ovf_hi <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        count <= next_count;
                        if (next_count == LO_V)
                            ovf_lo <= 1'b1;
                        if (next_count == HI_V) begin
                            ovf_hi <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= HALT;
                        end
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Count  = count;
    assign bus.Busy   = busy;
    assign bus.Ovf_lo = ovf_lo;
    assign bus.Ovf_hi = ovf_hi;
    assign bus.Done   = done;

endmodule
